// File: rtl/ldpc_iter_ctrl.sv
// Iteration controller for the flooding LDPC decoder: LLR load, CNU/VNU phase sequencing,
// parity check and hard-decision output. Optional macro EARLY_TERM_EN enables stop on syn_ok.
module ldpc_iter_ctrl #(
  parameter int data_w   = 8,
  parameter int R        = 5,
  parameter int C        = 3,
  parameter int D        = 8,
  parameter int MAX_ITER = 10,
  parameter int ITER_W   = 4,
  parameter int CNU_LAT  = 2,
  parameter int VNU_LAT  = 2,
  parameter int AW       = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [data_w-1:0] in_llr,
  output logic              llr_we,
  output logic [AW-1:0]     llr_addr,
  output logic [data_w-1:0] llr_wdata,
  output logic              msg_clr,
  output logic              cnu_en,
  output logic              vnu_en,
  input  logic [R*D-1:0]    dec,
  input  logic              syn_ok,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [R*D-1:0]    out_bits,
  output logic [ITER_W-1:0] out_iter,
  output logic              out_conv,
  output logic              busy
);

  localparam int N       = R * D;
  localparam int LAT_MAX = (CNU_LAT > VNU_LAT) ? CNU_LAT : VNU_LAT;
  localparam int PH_W    = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  if (C < 1 || CNU_LAT < 1 || VNU_LAT < 1 || MAX_ITER < 1 ||
      MAX_ITER > (2 ** ITER_W) - 1 || (2 ** AW) < N) begin : g_bad_param
    $error("ldpc_iter_ctrl: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CNU   = 3'd2,
    S_VNU   = 3'd3,
    S_CHECK = 3'd4,
    S_OUT   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     ld_cnt_q, ld_cnt_d;
  logic [PH_W-1:0]   ph_cnt_q, ph_cnt_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [N-1:0]      out_bits_q, out_bits_d;
  logic [ITER_W-1:0] out_iter_q, out_iter_d;
  logic              out_conv_q, out_conv_d;
  logic              accept_s;

  // A beat held during reset is not written; the reset edge discards it.
  assign in_ready  = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign accept_s  = in_valid && in_ready && rst;
  assign llr_we    = accept_s;
  assign llr_addr  = ld_cnt_q;
  assign llr_wdata = accept_s ? in_llr : {data_w{1'b0}};
  assign msg_clr   = accept_s && (state_q == S_IDLE);
  assign cnu_en    = (state_q == S_CNU);
  assign vnu_en    = (state_q == S_VNU);
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign out_bits  = out_bits_q;
  assign out_iter  = out_iter_q;
  assign out_conv  = out_conv_q;

  // Next-state and counter update logic.
  always_comb begin
    state_d    = state_q;
    ld_cnt_d   = ld_cnt_q;
    ph_cnt_d   = ph_cnt_q;
    iter_d     = iter_q;
    out_bits_d = out_bits_q;
    out_iter_d = out_iter_q;
    out_conv_d = out_conv_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          if (N == 1) begin
            state_d  = S_CNU;
            ld_cnt_d = AW'(0);
            ph_cnt_d = PH_W'(0);
            iter_d   = ITER_W'(1);
          end else begin
            state_d  = S_LOAD;
            ld_cnt_d = AW'(1);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (accept_s) begin
          if (ld_cnt_q == AW'(N - 1)) begin
            state_d  = S_CNU;
            ld_cnt_d = AW'(0);
            ph_cnt_d = PH_W'(0);
            iter_d   = ITER_W'(1);
          end else begin
            ld_cnt_d = ld_cnt_q + AW'(1);
          end
        end else begin
          ld_cnt_d = ld_cnt_q;
        end
      end
      S_CNU: begin
        if (ph_cnt_q == PH_W'(CNU_LAT - 1)) begin
          state_d  = S_VNU;
          ph_cnt_d = PH_W'(0);
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end
      S_VNU: begin
        if (ph_cnt_q == PH_W'(VNU_LAT - 1)) begin
          state_d  = S_CHECK;
          ph_cnt_d = PH_W'(0);
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end
      S_CHECK: begin
        out_bits_d = dec;
        out_iter_d = iter_q;
`ifdef EARLY_TERM_EN
        if (syn_ok) begin
          out_conv_d = 1'b1;
          state_d    = S_OUT;
        end else if (iter_q == ITER_W'(MAX_ITER)) begin
          out_conv_d = 1'b0;
          state_d    = S_OUT;
        end else begin
          iter_d  = iter_q + ITER_W'(1);
          state_d = S_CNU;
        end
`else
        if (iter_q == ITER_W'(MAX_ITER)) begin
          out_conv_d = syn_ok;
          state_d    = S_OUT;
        end else begin
          iter_d  = iter_q + ITER_W'(1);
          state_d = S_CNU;
        end
`endif
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
          iter_d  = ITER_W'(0);
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d  = S_IDLE;
        ld_cnt_d = AW'(0);
        ph_cnt_d = PH_W'(0);
        iter_d   = ITER_W'(0);
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ld_cnt_q   <= AW'(0);
      ph_cnt_q   <= PH_W'(0);
      iter_q     <= ITER_W'(0);
      out_bits_q <= {N{1'b0}};
      out_iter_q <= ITER_W'(0);
      out_conv_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_cnt_q   <= ld_cnt_d;
      ph_cnt_q   <= ph_cnt_d;
      iter_q     <= iter_d;
      out_bits_q <= out_bits_d;
      out_iter_q <= out_iter_d;
      out_conv_q <= out_conv_d;
    end
  end

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Self-checking bench for ldpc_iter_ctrl: table of frames, scoreboard of decoded words,
// per-cycle phase model and reset-in-every-state sequences.
module tb_ldpc_iter_ctrl;
  localparam int DW = 8, R = 5, C = 3, D = 8, N = R * D, MAXI = 10, IW = 4;
  localparam int CL = 2, VL = 2, AW = 6, IT_CYC = CL + VL + 1, NV = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_llr = 8'd0;
  logic          in_ready, llr_we, msg_clr, cnu_en, vnu_en, out_valid, out_conv, busy, syn_ok;
  logic [AW-1:0] llr_addr;
  logic [DW-1:0] llr_wdata;
  logic [N-1:0]  dec, out_bits, cur_base = 40'd0;
  logic [IW-1:0] out_iter;
  logic [7:0]    vcnt = 8'd0, ncnt = 8'd0;
  int            syn_iter = 0, cyc = 0, n_chk = 0, n_pass = 0;

  typedef struct { int syn_iter; bit gaps; int rdy_dly; logic [N-1:0] base; int exp_iter; bit exp_conv; } vec_t;
  typedef struct { logic [N-1:0] bits; int iter; bit conv; } exp_t;
  vec_t v[NV];
  exp_t sb[$];

  ldpc_iter_ctrl #(.data_w(DW), .R(R), .C(C), .D(D), .MAX_ITER(MAXI), .ITER_W(IW),
                   .CNU_LAT(CL), .VNU_LAT(VL), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_llr(in_llr),
    .llr_we(llr_we), .llr_addr(llr_addr), .llr_wdata(llr_wdata), .msg_clr(msg_clr),
    .cnu_en(cnu_en), .vnu_en(vnu_en), .dec(dec), .syn_ok(syn_ok), .out_valid(out_valid),
    .out_ready(out_ready), .out_bits(out_bits), .out_iter(out_iter), .out_conv(out_conv),
    .busy(busy));

  function automatic logic [N-1:0] mix(input logic [7:0] x);
    return {5{x}};
  endfunction

  function automatic logic [DW-1:0] llr_val(input int i);
    return 8'((i * 37) + 11);
  endfunction

  // Decoder array stand-in: decisions evolve with VNU activity, scramble while the word waits.
  assign syn_ok = (syn_iter != 0) && (int'(vcnt) >= VL * syn_iter);
  assign dec    = out_valid ? (~(cur_base ^ mix(vcnt)) ^ {5{ncnt}}) : (cur_base ^ mix(vcnt));

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst || (in_valid && in_ready && !busy)) vcnt <= 8'd0;
    else if (vnu_en) vcnt <= vcnt + 8'd1;
    if (out_valid) ncnt <= ncnt + 8'd1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    int exp_addr = 0, cnu_n = 0, vnu_n = 0, last_cyc = 0, o, k, p;
    bit ld_m = 1'b1, idle_m = 1'b1, run_m = 1'b0, prev_ov = 1'b0, prev_hs = 1'b0, acc, hs;
    logic [N-1:0] prev_bits;
    logic [IW-1:0] prev_iter;
    logic prev_conv;
    exp_t e;
    prev_bits = '0; prev_iter = '0; prev_conv = 1'b0;
    forever begin
      @(negedge clk);
      acc = in_valid && ld_m && rst;
      check("in_ready", in_ready, ld_m);
      check("busy", busy, !idle_m);
      check("llr_we", llr_we, acc);
      if (acc) begin
        check("llr_addr", llr_addr, exp_addr);
        check("llr_wdata", llr_wdata, llr_val(exp_addr));
        check("msg_clr", msg_clr, exp_addr == 0);
      end else begin
        check("msg_clr_nobeat", msg_clr, 0);
      end
      if (run_m) begin
        k = (sb.size() > 0) ? sb[0].iter : MAXI;
        o = cyc - last_cyc;
        if (o <= k * IT_CYC) begin
          p = (o - 1) % IT_CYC;
          check("cnu_en_seq", cnu_en, p < CL);
          check("vnu_en_seq", vnu_en, (p >= CL) && (p < CL + VL));
          check("out_valid_early", out_valid, 0);
        end else begin
          check("out_valid_rise", out_valid, 1);
          run_m = 1'b0;
        end
      end else begin
        check("cnu_en_off", cnu_en, 0);
        check("vnu_en_off", vnu_en, 0);
      end
      if (out_valid && prev_ov && !prev_hs) begin
        check("out_bits_stable", out_bits, prev_bits);
        check("out_iter_stable", out_iter, prev_iter);
        check("out_conv_stable", out_conv, prev_conv);
      end
      hs = out_valid && out_ready;
      if (hs) begin
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("out_bits", out_bits, e.bits);
          check("out_iter", out_iter, e.iter);
          check("out_conv", out_conv, e.conv);
          check("cnu_cycles", cnu_n, CL * e.iter);
          check("vnu_cycles", vnu_n, VL * e.iter);
        end
      end
      prev_ov = out_valid; prev_hs = hs; prev_bits = out_bits; prev_iter = out_iter; prev_conv = out_conv;
      if (!rst) begin
        exp_addr = 0; ld_m = 1'b1; idle_m = 1'b1; run_m = 1'b0;
      end else begin
        if (acc) begin
          if (exp_addr == 0) begin idle_m = 1'b0; cnu_n = 0; vnu_n = 0; end
          if (exp_addr == N - 1) begin ld_m = 1'b0; run_m = 1'b1; last_cyc = cyc; exp_addr = 0; end
          else exp_addr++;
        end
        if (cnu_en) cnu_n++;
        if (vnu_en) vnu_n++;
        if (hs) begin ld_m = 1'b1; idle_m = 1'b1; end
      end
    end
  endtask

  task automatic load(input bit gaps, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      in_valid = 1'b1;
      in_llr   = llr_val(b);
      tick();
      if (gaps && (b == 7 || b == 23)) begin
        in_valid = 1'b0;
        in_llr   = 8'hA5;
        repeat (3) tick();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_ov(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < MAXI * IT_CYC + 20; i++) begin
      if (out_valid) begin ok = 1'b1; break; end
      tick();
    end
    check("out_valid_seen", ok, 1);
  endtask

  task automatic run_vec(input vec_t t);
    exp_t e;
    bit ok;
    e.bits = t.base ^ mix(8'(VL * t.exp_iter));
    e.iter = t.exp_iter;
    e.conv = t.exp_conv;
    sb.push_back(e);
    cur_base  = t.base;
    syn_iter  = t.syn_iter;
    out_ready = (t.rdy_dly == 0);
    load(t.gaps, N);
    wait_ov(ok);
    if (ok) begin
      repeat (t.rdy_dly) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    check("sb_drained", sb.size(), 0);
    check("idle_after_frame", busy, 0);
    sb.delete();
  endtask

  task automatic reset_test(input int s);
    bit ok;
    cur_base  = 40'h5A_C3_96_0F_E1 ^ 40'(s);
    syn_iter  = 0;
    out_ready = 1'b0;
    case (s)
      1: load(1'b0, 10);
      2: begin load(1'b0, N); tick(); end
      3: begin load(1'b0, N); repeat (12) tick(); end
      4: begin load(1'b0, N); repeat (4) tick(); end
      5: begin load(1'b0, N); wait_ov(ok); check("out_bits_before_rst", out_bits != '0, 1); end
      default: tick();
    endcase
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check($sformatf("rst%0d_busy", s), busy, 0);
    check($sformatf("rst%0d_in_ready", s), in_ready, 1);
    check($sformatf("rst%0d_enables", s), {cnu_en, vnu_en, msg_clr, llr_we}, 4'b0000);
    check($sformatf("rst%0d_out_valid", s), out_valid, 0);
    check($sformatf("rst%0d_out_conv", s), out_conv, 0);
    check($sformatf("rst%0d_out_bits", s), out_bits, 0);
    check($sformatf("rst%0d_out_iter", s), out_iter, 0);
    check($sformatf("rst%0d_llr_addr", s), llr_addr, 0);
  endtask

  initial begin
    v[0] = '{1,  1'b0, 0, 40'h12_3456_789A, 0, 1'b0};
    v[1] = '{0,  1'b0, 0, 40'hF0_0F_A5_5A_C3, 0, 1'b0};
    v[2] = '{0,  1'b1, 0, 40'h0F_1E_2D_3C_4B, 0, 1'b0};
    v[3] = '{3,  1'b0, 6, 40'hDE_AD_BE_EF_01, 0, 1'b0};
    v[4] = '{2,  1'b0, 0, 40'h81_42_24_18_FF, 0, 1'b0};
    v[5] = '{10, 1'b0, 1, 40'h33_CC_55_AA_77, 0, 1'b0};
    for (int i = 0; i < NV; i++) begin
`ifdef EARLY_TERM_EN
      v[i].exp_iter = (v[i].syn_iter >= 1 && v[i].syn_iter <= MAXI) ? v[i].syn_iter : MAXI;
`else
      v[i].exp_iter = MAXI;
`endif
      v[i].exp_conv = (v[i].syn_iter >= 1 && v[i].syn_iter <= MAXI);
    end
    fork
      monitor();
    join_none
    repeat (2) tick();
    check("init_busy", busy, 0);
    check("init_in_ready", in_ready, 1);
    check("init_out_valid", out_valid, 0);
    check("init_out_iter", out_iter, 0);
    rst = 1'b1;
    tick();
    for (int s = 0; s < 6; s++) reset_test(s);
    for (int i = 0; i < NV; i++) run_vec(v[i]);
    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
